// File: rtl/data_table_remove.sv
// Hash-table delete engine: walks a bucket chain, unlinks and clears the matching entry, frees its address.
// Optional statistics counters are built when HT_DELETE_STATS_EN is defined.
module data_table_remove #(
  parameter int KEY_WIDTH     = 32,
  parameter int VALUE_WIDTH   = 16,
  parameter int A_WIDTH       = 8,
  parameter int BUCKET_WIDTH  = 8,
  parameter int RAM_LATENCY   = 2,
  parameter int MAX_CHAIN_LEN = 256,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                                            clk_i,
  input  logic                                            rst_n_i,
  input  logic [KEY_WIDTH+VALUE_WIDTH+BUCKET_WIDTH+A_WIDTH:0] task_i,
  input  logic                                            task_valid_i,
  output logic                                            task_ready_o,
  output logic [A_WIDTH-1:0]                              rd_addr_o,
  output logic                                            rd_en_o,
  input  logic [KEY_WIDTH+VALUE_WIDTH+A_WIDTH:0]          rd_data_i,
  output logic [A_WIDTH-1:0]                              wr_addr_o,
  output logic [KEY_WIDTH+VALUE_WIDTH+A_WIDTH:0]          wr_data_o,
  output logic                                            wr_en_o,
  output logic [A_WIDTH-1:0]                              add_empty_ptr_o,
  output logic                                            add_empty_ptr_en_o,
  output logic [BUCKET_WIDTH-1:0]                         head_wr_addr_o,
  output logic [A_WIDTH-1:0]                              head_wr_ptr_o,
  output logic                                            head_wr_ptr_val_o,
  output logic                                            head_wr_en_o,
  output logic [KEY_WIDTH+VALUE_WIDTH+1:0]                result_o,
  output logic                                            result_valid_o,
  input  logic                                            result_ready_i
`ifdef HT_DELETE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]                           stat_ok_o,
  output logic [STAT_WIDTH-1:0]                           stat_miss_o,
  output logic [STAT_WIDTH-1:0]                           stat_err_o
`endif
);

  localparam int D  = KEY_WIDTH + VALUE_WIDTH + 1 + A_WIDTH;
  localparam int HW = $clog2(MAX_CHAIN_LEN + 1);
  localparam logic [HW-1:0] HOP_MAX = HW'(MAX_CHAIN_LEN);
  localparam logic [HW-1:0] HOP_ONE = HW'(1);

  typedef enum logic [3:0] {
    IDLE, READ, MATCH_HEAD, MATCH_MID, MATCH_TAIL, CLEAR, DONE, NO_HEAD, MISS, CHAIN_ERR
  } state_t;

  // Handshakes: task and result each transfer on a cycle where valid and ready are both high.
  state_t                  state_q, state_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [VALUE_WIDTH-1:0]  value_q, value_d;
  logic [BUCKET_WIDTH-1:0] bucket_q, bucket_d;
  logic [A_WIDTH-1:0]      cur_addr_q, cur_addr_d;
  logic [A_WIDTH-1:0]      prev_addr_q, prev_addr_d;
  logic [KEY_WIDTH-1:0]    prev_key_q, prev_key_d;
  logic [VALUE_WIDTH-1:0]  prev_value_q, prev_value_d;
  logic [A_WIDTH-1:0]      nxt_ptr_q, nxt_ptr_d;
  logic                    nxt_val_q, nxt_val_d;
  logic [HW-1:0]           hop_q, hop_d;
  logic                    rd_go_q, rd_go_d;
  logic [RAM_LATENCY-1:0]  vld_sr_q, vld_sr_d;

  logic [A_WIDTH-1:0]      t_ptr, r_ptr;
  logic                    t_hv, r_nv;
  logic [BUCKET_WIDTH-1:0] t_bucket;
  logic [VALUE_WIDTH-1:0]  t_value, r_value;
  logic [KEY_WIDTH-1:0]    t_key, r_key;
  logic [1:0]              res;
  logic                    res_hs;

  assign t_ptr    = task_i[A_WIDTH-1:0];
  assign t_hv     = task_i[A_WIDTH];
  assign t_bucket = task_i[A_WIDTH+1 +: BUCKET_WIDTH];
  assign t_value  = task_i[A_WIDTH+1+BUCKET_WIDTH +: VALUE_WIDTH];
  assign t_key    = task_i[A_WIDTH+1+BUCKET_WIDTH+VALUE_WIDTH +: KEY_WIDTH];

  assign r_ptr    = rd_data_i[A_WIDTH-1:0];
  assign r_nv     = rd_data_i[A_WIDTH];
  assign r_value  = rd_data_i[A_WIDTH+1 +: VALUE_WIDTH];
  assign r_key    = rd_data_i[A_WIDTH+1+VALUE_WIDTH +: KEY_WIDTH];

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    value_d      = value_q;
    bucket_d     = bucket_q;
    cur_addr_d   = cur_addr_q;
    prev_addr_d  = prev_addr_q;
    prev_key_d   = prev_key_q;
    prev_value_d = prev_value_q;
    nxt_ptr_d    = nxt_ptr_q;
    nxt_val_d    = nxt_val_q;
    hop_d        = hop_q;
    rd_go_d      = rd_go_q;
    vld_sr_d     = '0;

    task_ready_o       = 1'b0;
    rd_addr_o          = '0;
    rd_en_o            = 1'b0;
    wr_addr_o          = '0;
    wr_data_o          = '0;
    wr_en_o            = 1'b0;
    add_empty_ptr_o    = '0;
    add_empty_ptr_en_o = 1'b0;
    head_wr_addr_o     = '0;
    head_wr_ptr_o      = '0;
    head_wr_ptr_val_o  = 1'b0;
    head_wr_en_o       = 1'b0;
    result_valid_o     = 1'b0;
    res                = 2'd0;

    case (state_q)
      IDLE: begin
        task_ready_o = 1'b1;
        if (task_valid_i) begin
          key_d      = t_key;
          value_d    = t_value;
          bucket_d   = t_bucket;
          cur_addr_d = t_ptr;
          hop_d      = '0;
          rd_go_d    = t_hv;
          state_d    = t_hv ? READ : NO_HEAD;
        end
      end
      READ: begin
        vld_sr_d = vld_sr_q << 1;
        if (rd_go_q) begin
          rd_en_o     = 1'b1;
          rd_addr_o   = cur_addr_q;
          vld_sr_d[0] = 1'b1;
          rd_go_d     = 1'b0;
          hop_d       = (hop_q == HOP_MAX) ? hop_q : hop_q + HOP_ONE;
        end else if (vld_sr_q[RAM_LATENCY-1]) begin
          nxt_ptr_d = r_ptr;
          nxt_val_d = r_nv;
          // Match is tested before the hop limit so a hit on the last allowed read still succeeds.
          if (r_key == key_q) begin
            if (hop_q == HOP_ONE) state_d = MATCH_HEAD;
            else if (!r_nv)       state_d = MATCH_TAIL;
            else                  state_d = MATCH_MID;
          end else if (!r_nv) begin
            state_d = MISS;
          end else if (hop_q == HOP_MAX) begin
            state_d = CHAIN_ERR;
          end else begin
            prev_addr_d  = cur_addr_q;
            prev_key_d   = r_key;
            prev_value_d = r_value;
            cur_addr_d   = r_ptr;
            rd_go_d      = 1'b1;
          end
        end
      end
      MATCH_HEAD: begin
        head_wr_en_o      = 1'b1;
        head_wr_addr_o    = bucket_q;
        head_wr_ptr_o     = nxt_ptr_q;
        head_wr_ptr_val_o = nxt_val_q;
        state_d           = CLEAR;
      end
      MATCH_MID: begin
        wr_en_o   = 1'b1;
        wr_addr_o = prev_addr_q;
        wr_data_o = {prev_key_q, prev_value_q, nxt_val_q, nxt_ptr_q};
        state_d   = CLEAR;
      end
      MATCH_TAIL: begin
        wr_en_o   = 1'b1;
        wr_addr_o = prev_addr_q;
        wr_data_o = {prev_key_q, prev_value_q, 1'b0, {A_WIDTH{1'b0}}};
        state_d   = CLEAR;
      end
      CLEAR: begin
        wr_en_o            = 1'b1;
        wr_addr_o          = cur_addr_q;
        wr_data_o          = {D{1'b0}};
        add_empty_ptr_en_o = 1'b1;
        add_empty_ptr_o    = cur_addr_q;
        state_d            = DONE;
      end
      DONE, NO_HEAD, MISS, CHAIN_ERR: begin
        result_valid_o = 1'b1;
        res = (state_q == DONE) ? 2'd0 : (state_q == CHAIN_ERR) ? 2'd2 : 2'd1;
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    result_o = result_valid_o ? {res, key_q, value_q} : '0;
  end

  assign res_hs = result_valid_o & result_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      key_q        <= '0;
      value_q      <= '0;
      bucket_q     <= '0;
      cur_addr_q   <= '0;
      prev_addr_q  <= '0;
      prev_key_q   <= '0;
      prev_value_q <= '0;
      nxt_ptr_q    <= '0;
      nxt_val_q    <= 1'b0;
      hop_q        <= '0;
      rd_go_q      <= 1'b0;
      vld_sr_q     <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      value_q      <= value_d;
      bucket_q     <= bucket_d;
      cur_addr_q   <= cur_addr_d;
      prev_addr_q  <= prev_addr_d;
      prev_key_q   <= prev_key_d;
      prev_value_q <= prev_value_d;
      nxt_ptr_q    <= nxt_ptr_d;
      nxt_val_q    <= nxt_val_d;
      hop_q        <= hop_d;
      rd_go_q      <= rd_go_d;
      vld_sr_q     <= vld_sr_d;
    end
  end

`ifdef HT_DELETE_STATS_EN
  logic [STAT_WIDTH-1:0] stat_ok_q, stat_ok_d, stat_miss_q, stat_miss_d, stat_err_q, stat_err_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    stat_ok_d   = stat_ok_q;
    stat_miss_d = stat_miss_q;
    stat_err_d  = stat_err_q;
    if (res_hs) begin
      if (res == 2'd0 && stat_ok_q != '1)   stat_ok_d   = stat_ok_q + 1'b1;
      if (res == 2'd1 && stat_miss_q != '1) stat_miss_d = stat_miss_q + 1'b1;
      if (res == 2'd2 && stat_err_q != '1)  stat_err_d  = stat_err_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_ok_q   <= '0;
      stat_miss_q <= '0;
      stat_err_q  <= '0;
    end else begin
      stat_ok_q   <= stat_ok_d;
      stat_miss_q <= stat_miss_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign stat_ok_o   = stat_ok_q;
  assign stat_miss_o = stat_miss_q;
  assign stat_err_o  = stat_err_q;
`else
  logic unused_hs;
  assign unused_hs = res_hs;
`endif

endmodule

// File: tb/tb_data_table_remove.sv
// Directed bench for data_table_remove: RAM model, expected-event queue and a negedge monitor.
module tb_data_table_remove;
  localparam int K  = 32;
  localparam int V  = 16;
  localparam int A  = 8;
  localparam int B  = 8;
  localparam int L  = 2;
  localparam int D  = K + V + 1 + A;
  localparam int EW = 3 + 8 + 8 + D;

  logic             clk, rst_n;
  logic [K+V+B+A:0] task_i;
  logic             task_valid_i, task_ready_o;
  logic [A-1:0]     rd_addr_o, wr_addr_o, add_empty_ptr_o, head_wr_ptr_o;
  logic             rd_en_o, wr_en_o, add_empty_ptr_en_o, head_wr_ptr_val_o, head_wr_en_o;
  logic [D-1:0]     rd_data_i, wr_data_o;
  logic [B-1:0]     head_wr_addr_o;
  logic [K+V+1:0]   result_o;
  logic             result_valid_o, result_ready_i;
`ifdef HT_DELETE_STATS_EN
  logic [15:0]      stat_ok_o, stat_miss_o, stat_err_o;
`endif

  data_table_remove #(.KEY_WIDTH(K), .VALUE_WIDTH(V), .A_WIDTH(A), .BUCKET_WIDTH(B),
                      .RAM_LATENCY(L), .MAX_CHAIN_LEN(4), .STAT_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .task_i(task_i), .task_valid_i(task_valid_i),
    .task_ready_o(task_ready_o), .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o), .rd_data_i(rd_data_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o),
    .add_empty_ptr_o(add_empty_ptr_o), .add_empty_ptr_en_o(add_empty_ptr_en_o),
    .head_wr_addr_o(head_wr_addr_o), .head_wr_ptr_o(head_wr_ptr_o),
    .head_wr_ptr_val_o(head_wr_ptr_val_o), .head_wr_en_o(head_wr_en_o),
    .result_o(result_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i)
`ifdef HT_DELETE_STATS_EN
    , .stat_ok_o(stat_ok_o), .stat_miss_o(stat_miss_o), .stat_err_o(stat_err_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data appears L cycles after the read strobe
  logic [D-1:0] mem [0:255];
  logic [D-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= rd_en_o ? mem[rd_addr_o] : '0;
    p2 <= p1;
  end
  assign rd_data_i = p2;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cyc   = 0;
  bit res_seen = 0;
  logic [K+V+1:0] hold_exp;
  int exp_ok = 0, exp_miss = 0, exp_err = 0;

  function automatic logic [D-1:0] ent(input logic [K-1:0] k, input logic [V-1:0] v,
                                       input logic nv, input logic [A-1:0] np);
    return {k, v, nv, np};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [2:0] kind, input int rel, input logic [7:0] addr,
                         input logic [D-1:0] pay);
    exp_q.push_back({kind, 8'(rel), addr, pay});
  endtask

  task automatic push_res(input int rel, input logic [1:0] res, input logic [K-1:0] k,
                          input logic [V-1:0] v);
    logic [K+V+1:0] r;
    r = {res, k, v};
    push_ev(3'd4, rel, 8'd0, D'(r));
    if (res == 2'd0) exp_ok++;
    else if (res == 2'd1) exp_miss++;
    else exp_err++;
  endtask

  task automatic check_ev(input logic [EW-1:0] act);
    logic [EW-1:0] e;
    string nm;
    case (act[EW-1 -: 3])
      3'd1: nm = "head_wr";
      3'd2: nm = "ram_wr";
      3'd3: nm = "free_ptr";
      3'd4: nm = "result";
      default: nm = "rd_en";
    endcase
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s got=%h exp=none", nm, act);
      hold_exp = act[K+V+1:0];
    end else begin
      e = exp_q.pop_front();
      hold_exp = e[K+V+1:0];
      if (e !== act) begin
        n_fail++;
        $display("FAIL %s got=%h exp=%h", nm, act, e);
      end
    end
  endtask

  // monitor: event = {kind, cycle offset from task handshake, address, payload}
  always @(negedge clk) begin
    logic [7:0] rel;
    cyc++;
    if (rst_n) begin
      if (task_valid_i && task_ready_o) hs_cyc = cyc;
      rel = 8'(cyc - hs_cyc);
      if (rd_en_o)            check_ev({3'd5, rel, rd_addr_o, {D{1'b0}}});
      if (head_wr_en_o)       check_ev({3'd1, rel, head_wr_addr_o, D'({head_wr_ptr_val_o, head_wr_ptr_o})});
      if (wr_en_o)            check_ev({3'd2, rel, wr_addr_o, wr_data_o});
      if (add_empty_ptr_en_o) check_ev({3'd3, rel, add_empty_ptr_o, {D{1'b0}}});
      if (result_valid_o) begin
        if (!res_seen) begin
          check_ev({3'd4, rel, 8'd0, D'(result_o)});
          res_seen = 1;
        end else begin
          chk("result_hold", 64'(result_o), 64'(hold_exp));
        end
      end else begin
        res_seen = 0;
      end
    end
  end

  // driver
  task automatic run_task(input logic [K-1:0] k, input logic [V-1:0] v, input logic [B-1:0] b,
                          input logic hv, input logic [A-1:0] hp, input int hold);
    @(posedge clk); #1;
    task_i = {k, v, b, hv, hp};
    task_valid_i = 1'b1;
    @(posedge clk); #1;
    task_valid_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!result_valid_o) begin
        @(posedge clk); #1;
      end
    end
    if (!result_valid_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout got=0 exp=1");
    end else begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      result_ready_i = 1'b1;
      @(posedge clk); #1;
      result_ready_i = 1'b0;
      chk("valid_drop", 64'(result_valid_o), 64'd0);
      chk("ready_back", 64'(task_ready_o), 64'd1);
    end
  endtask

  task automatic load_chain;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h05] = ent(32'hA1, 16'h0101, 1'b1, 8'h09);
    mem[8'h09] = ent(32'hB2, 16'h0202, 1'b1, 8'h0C);
    mem[8'h0C] = ent(32'hC3, 16'h0303, 1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    task_i = '0;
    task_valid_i = 1'b0;
    result_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #3;
    chk("rst_task_ready", 64'(task_ready_o), 64'd1);
    chk("rst_result_valid", 64'(result_valid_o), 64'd0);
    chk("rst_strobes", 64'({rd_en_o, wr_en_o, head_wr_en_o, add_empty_ptr_en_o}), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // no head pointer
    push_res(1, 2'd1, 32'h11, 16'h2222);
    run_task(32'h11, 16'h2222, 8'h03, 1'b0, 8'h00, 0);

    // single entry match at the head
    mem[8'h05] = ent(32'hAA, 16'h1234, 1'b0, 8'h00);
    push_ev(3'd5, 1, 8'h05, '0);
    push_ev(3'd1, 4, 8'h07, D'(9'h000));
    push_ev(3'd2, 5, 8'h05, '0);
    push_ev(3'd3, 5, 8'h05, '0);
    push_res(6, 2'd0, 32'hAA, 16'h5555);
    run_task(32'hAA, 16'h5555, 8'h07, 1'b1, 8'h05, 0);

    // head match with a successor: head moves to 0x09
    load_chain();
    push_ev(3'd5, 1, 8'h05, '0);
    push_ev(3'd1, 4, 8'h02, D'({1'b1, 8'h09}));
    push_ev(3'd2, 5, 8'h05, '0);
    push_ev(3'd3, 5, 8'h05, '0);
    push_res(6, 2'd0, 32'hA1, 16'h0001);
    run_task(32'hA1, 16'h0001, 8'h02, 1'b1, 8'h05, 0);

    // middle delete
    load_chain();
    push_ev(3'd5, 1, 8'h05, '0);
    push_ev(3'd5, 4, 8'h09, '0);
    push_ev(3'd2, 7, 8'h05, ent(32'hA1, 16'h0101, 1'b1, 8'h0C));
    push_ev(3'd2, 8, 8'h09, '0);
    push_ev(3'd3, 8, 8'h09, '0);
    push_res(9, 2'd0, 32'hB2, 16'h0002);
    run_task(32'hB2, 16'h0002, 8'h02, 1'b1, 8'h05, 0);

    // tail delete
    load_chain();
    push_ev(3'd5, 1, 8'h05, '0);
    push_ev(3'd5, 4, 8'h09, '0);
    push_ev(3'd5, 7, 8'h0C, '0);
    push_ev(3'd2, 10, 8'h09, ent(32'hB2, 16'h0202, 1'b0, 8'h00));
    push_ev(3'd2, 11, 8'h0C, '0);
    push_ev(3'd3, 11, 8'h0C, '0);
    push_res(12, 2'd0, 32'hC3, 16'h0003);
    run_task(32'hC3, 16'h0003, 8'h02, 1'b1, 8'h05, 0);

    // miss after three reads, result held with ready low for 5 cycles
    load_chain();
    push_ev(3'd5, 1, 8'h05, '0);
    push_ev(3'd5, 4, 8'h09, '0);
    push_ev(3'd5, 7, 8'h0C, '0);
    push_res(10, 2'd1, 32'hDD, 16'hBEEF);
    run_task(32'hDD, 16'hBEEF, 8'h02, 1'b1, 8'h05, 5);

    // self-loop without match: exactly 4 reads then chain error
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h03] = ent(32'h77, 16'h0707, 1'b1, 8'h03);
    for (int k = 1; k <= 4; k++) push_ev(3'd5, (k - 1) * 3 + 1, 8'h03, '0);
    push_res(13, 2'd2, 32'h99, 16'h0909);
    run_task(32'h99, 16'h0909, 8'h01, 1'b1, 8'h03, 0);

    // match on the 4th (last allowed) read, entry still linked onward -> middle unlink
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = ent(32'hE1, 16'h0E01, 1'b1, 8'h11);
    mem[8'h11] = ent(32'hE2, 16'h0E02, 1'b1, 8'h12);
    mem[8'h12] = ent(32'hE3, 16'h0E03, 1'b1, 8'h13);
    mem[8'h13] = ent(32'hE4, 16'h0E04, 1'b1, 8'h10);
    for (int k = 1; k <= 4; k++) push_ev(3'd5, (k - 1) * 3 + 1, 8'(8'h0F + k), '0);
    push_ev(3'd2, 13, 8'h12, ent(32'hE3, 16'h0E03, 1'b1, 8'h10));
    push_ev(3'd2, 14, 8'h13, '0);
    push_ev(3'd3, 14, 8'h13, '0);
    push_res(15, 2'd0, 32'hE4, 16'h4444);
    run_task(32'hE4, 16'h4444, 8'h04, 1'b1, 8'h10, 2);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef HT_DELETE_STATS_EN
    chk("stat_ok", 64'(stat_ok_o), 64'(exp_ok));
    chk("stat_miss", 64'(stat_miss_o), 64'(exp_miss));
    chk("stat_err", 64'(stat_err_o), 64'(exp_err));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
